// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with single/double-word access, zero-clear sweep after reset, configurable wait states.
// Latency (WAIT_STATES+1)*(dbl?2:1)+1 cycles to ready; busy stalls the requester, and a req during DONE is taken back-to-back.
module data_mem_ctrl #(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12,
    parameter int WAIT_STATES   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       we,
    input  logic                       dbl,
    input  logic [ADDRESS_SPACE-1:0]   addr,
    input  logic [2*WORD_LENGTH-1:0]   wdata,
    output logic [2*WORD_LENGTH-1:0]   rdata,
    output logic                       ready,
    output logic                       busy,
    output logic                       init_done
);
    localparam int DEPTH = 2**ADDRESS_SPACE;
    localparam int WL    = WORD_LENGTH;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_ACC, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_SPACE-1:0] ptr_q, ptr_d;
    logic [ADDRESS_SPACE-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic                     dbl_q, dbl_d;
    logic                     idx_q, idx_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [2*WL-1:0]          wdata_q, wdata_d;
    logic [2*WL-1:0]          rdata_q, rdata_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     init_done_q, init_done_d;

    logic                     mem_we;
    logic [ADDRESS_SPACE-1:0] mem_waddr;
    logic [WL-1:0]            mem_wdat;
    logic [WL-1:0]            mem_rd;
    logic [ADDRESS_SPACE-1:0] acc_addr;
    logic [WL-1:0]            mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        we_d        = we_q;
        dbl_d       = dbl_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdat    = '0;
        // Second word of a double access wraps naturally at the top of the array.
        acc_addr    = addr_q + ADDRESS_SPACE'(idx_q);
        mem_rd      = mem[acc_addr];

        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + ADDRESS_SPACE'(1);
                if (ptr_q == '1) state_d = S_IDLE;
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    dbl_d   = dbl;
                    wdata_d = wdata;
                    idx_d   = 1'b0;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACC : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = S_ACC;
            end
            S_ACC: begin
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = acc_addr;
                    mem_wdat  = idx_q ? wdata_q[2*WL-1:WL] : wdata_q[WL-1:0];
                end else if (idx_q) begin
                    rdata_d[2*WL-1:WL] = mem_rd;
                end else begin
                    rdata_d[WL-1:0] = mem_rd;
                    if (!dbl_q) rdata_d[2*WL-1:WL] = '0;
                end
                if (dbl_q && !idx_q) begin
                    idx_d   = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACC : S_WAIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d      = !(state_d == S_IDLE || state_d == S_DONE);
        ready_d     = (state_d == S_DONE);
        init_done_d = init_done_q | (state_q == S_INIT && state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            ptr_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            dbl_q       <= 1'b0;
            idx_q       <= 1'b0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            dbl_q       <= dbl_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    // Reset on the same edge cancels any pending word write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdat;
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: index 0 is a WAIT_STATES=0 instance, index 1 a WAIT_STATES=1 instance, both 16 words deep.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req       [2];
    logic        we        [2];
    logic        dbl       [2];
    logic [3:0]  addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic        ready     [2];
    logic        busy      [2];
    logic        init_done [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.WORD_LENGTH(16), .ADDRESS_SPACE(4), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .dbl(dbl[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .ready(ready[0]), .busy(busy[0]), .init_done(init_done[0])
    );

    data_mem_ctrl #(.WORD_LENGTH(16), .ADDRESS_SPACE(4), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .dbl(dbl[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .ready(ready[1]), .busy(busy[1]), .init_done(init_done[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called one negedge after the accept edge; that negedge is cycle 1.
    task automatic wait_ready(input int s, output int lat, output logic ov);
        lat = 1;
        ov  = 1'b0;
        while (!ready[s] && lat < 50) begin
            if (ready[s] && busy[s]) ov = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (ready[s] && busy[s]) ov = 1'b1;
    endtask

    task automatic access(input int s, input logic w, input logic d, input logic [3:0] a,
                          input logic [31:0] wd, input int exp_lat, input string tag);
        int   lat;
        logic ov;
        check({tag, "_idle"}, 32'(busy[s]), 32'd0);
        req[s] = 1'b1; we[s] = w; dbl[s] = d; addr[s] = a; wdata[s] = wd;
        @(negedge clk);
        req[s] = 1'b0;
        wait_ready(s, lat, ov);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdy_busy"}, 32'(ov), 32'd0);
    endtask

    initial begin
        int          lat;
        int          bad;
        int          nrdy;
        logic        ov;
        int          rdy_cyc [3];
        logic [31:0] rdy_dat [3];

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; dbl[i] = 1'b0;
            addr[i] = 4'd0; wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy[1]),      32'd1);
        check("rst_init_done", 32'(init_done[1]), 32'd0);
        check("rst_ready",     32'(ready[1]),     32'd0);
        check("rst_rdata",     rdata[1],          32'd0);

        // Sweep with req held high: nothing may be accepted until init_done.
        rst[0] = 1'b0; rst[1] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; dbl[1] = 1'b0; addr[1] = 4'd5;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (busy[1] !== 1'b1 || init_done[1] !== 1'b0 || ready[1] !== 1'b0) bad++;
        end
        check("init_sweep_flags", 32'(bad), 32'd0);
        @(negedge clk);
        check("init_done_rise", 32'(init_done[1]), 32'd1);
        check("init_busy_low",  32'(busy[1]),      32'd0);
        @(negedge clk);
        req[1] = 1'b0;
        wait_ready(1, lat, ov);
        check("held_rd5_lat",   32'(lat), 32'd3);
        check("held_rd5_rdata", rdata[1], 32'h0000_0000);

        access(1, 1'b1, 1'b0, 4'd3, 32'h0000_BEEF, 3, "wr3");
        check("wr3_rdata_hold", rdata[1], 32'h0000_0000);
        access(1, 1'b0, 1'b0, 4'd3, 32'h0, 3, "rd3");
        check("rd3_rdata", rdata[1], 32'h0000_BEEF);

        access(1, 1'b1, 1'b1, 4'd15, 32'h1234_5678, 5, "dwr15");
        check("dwr15_rdata_hold", rdata[1], 32'h0000_BEEF);
        access(1, 1'b0, 1'b0, 4'd15, 32'h0, 3, "rd15");
        check("rd15_rdata", rdata[1], 32'h0000_5678);
        access(1, 1'b0, 1'b0, 4'd0, 32'h0, 3, "rd0");
        check("rd0_rdata", rdata[1], 32'h0000_1234);
        access(1, 1'b0, 1'b1, 4'd15, 32'h0, 5, "drd15");
        check("drd15_rdata", rdata[1], 32'h1234_5678);

        // Extra req pulse while busy must not alter the in-flight write.
        check("pulse_idle", 32'(busy[1]), 32'd0);
        req[1] = 1'b1; we[1] = 1'b1; dbl[1] = 1'b0; addr[1] = 4'd9; wdata[1] = 32'h0000_1111;
        @(negedge clk);
        addr[1] = 4'd10; wdata[1] = 32'h0000_2222;
        @(negedge clk);
        req[1] = 1'b0;
        lat = 2;
        while (!ready[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("pulse_lat", 32'(lat), 32'd3);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready[1] !== 1'b0) bad++;
        end
        check("pulse_no_extra_ready", 32'(bad), 32'd0);
        access(1, 1'b0, 1'b0, 4'd9, 32'h0, 3, "rd9");
        check("rd9_rdata", rdata[1], 32'h0000_1111);
        access(1, 1'b0, 1'b0, 4'd10, 32'h0, 3, "rd10");
        check("rd10_rdata", rdata[1], 32'h0000_0000);

        // Reset lands while a write to addr 7 sits in WAIT.
        req[1] = 1'b1; we[1] = 1'b1; dbl[1] = 1'b0; addr[1] = 4'd7; wdata[1] = 32'h0000_AAAA;
        @(negedge clk);
        req[1] = 1'b0; rst[1] = 1'b1;
        @(negedge clk);
        check("midrst_busy",      32'(busy[1]),      32'd1);
        check("midrst_init_done", 32'(init_done[1]), 32'd0);
        check("midrst_rdata",     rdata[1],          32'd0);
        rst[1] = 1'b0;
        lat = 0; bad = 0;
        while (!init_done[1] && lat < 40) begin
            if (ready[1] !== 1'b0 || busy[1] !== 1'b1) bad++;
            @(negedge clk);
            lat++;
        end
        check("midrst_sweep_len",   32'(lat), 32'd16);
        check("midrst_no_ready",    32'(bad), 32'd0);
        access(1, 1'b0, 1'b0, 4'd7, 32'h0, 3, "rd7");
        check("rd7_rdata", rdata[1], 32'h0000_0000);

        // Zero-wait instance: seed three words, then back-to-back reads with req held.
        check("ws0_init_done", 32'(init_done[0]), 32'd1);
        access(0, 1'b1, 1'b0, 4'd1, 32'h0000_0011, 2, "ws0_wr1");
        access(0, 1'b1, 1'b0, 4'd2, 32'h0000_0022, 2, "ws0_wr2");
        access(0, 1'b1, 1'b0, 4'd3, 32'h0000_0033, 2, "ws0_wr3");
        req[0] = 1'b1; we[0] = 1'b0; dbl[0] = 1'b0; addr[0] = 4'd1;
        nrdy = 0; ov = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ready[0] && busy[0]) ov = 1'b1;
            if (ready[0]) begin
                if (nrdy < 3) begin
                    rdy_cyc[nrdy] = c;
                    rdy_dat[nrdy] = rdata[0];
                end
                nrdy++;
                addr[0] = addr[0] + 4'd1;
                if (nrdy == 3) req[0] = 1'b0;
            end
        end
        check("b2b_count",   32'(nrdy), 32'd3);
        check("b2b_overlap", 32'(ov),   32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_cyc%0d", k), 32'(rdy_cyc[k]), 32'(2 * (k + 1)));
            check($sformatf("b2b_dat%0d", k), rdy_dat[k], 32'h11 * 32'(k + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
